// File: rtl/store_merge_unit_pkg.sv
// Shared definitions for the store path: memory access-size codes, the
// store FSM state encoding and the alignment rule used at accept time.
package store_merge_unit_pkg;

  // Access-size codes carried on st_size.
  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'b00,
    MEM_SIZE_HALF = 2'b01,
    MEM_SIZE_WORD = 2'b10,
    MEM_SIZE_ILL  = 2'b11
  } mem_size_e;

  // Store FSM states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  // True when a request must be rejected: illegal size, or the byte offset
  // does not sit on the natural boundary of the access size.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] offset);
    logic bad;
    case (size)
      MEM_SIZE_BYTE: bad = 1'b0;
      MEM_SIZE_HALF: bad = offset[0];
      MEM_SIZE_WORD: bad = (offset != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// store_lane_merge: combinational little-endian lane insert.
// Places the low byte/half of data into the lane selected by offset and keeps
// the remaining lanes of old_word; a word access replaces the whole word.
// Ports:
//   old_word  in   32  word currently held in memory
//   data      in   32  register value being stored
//   size      in   2   access size (byte/half/word/illegal)
//   offset    in   2   byte address bits [1:0]
//   merged    out  32  word to write back
module store_lane_merge
  import store_merge_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  mem_size_e   size,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  // NOTE: every output of a combinational block gets a default on entry so
  // no path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    merged = old_word;
    case (size)
      MEM_SIZE_BYTE: merged[{offset, 3'b000} +: 8]     = data[7:0];
      MEM_SIZE_HALF: merged[{offset[1], 4'b0000} +: 16] = data[15:0];
      MEM_SIZE_WORD: merged = data;
      default:       merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// store_merge_unit: store path for sb/sh/sw between the MEM stage and a
// word-addressed, synchronously read data memory. Word stores write directly;
// byte/half stores read the target word, merge the new lane and write back.
// Illegal or misaligned requests are rejected with a one-cycle pulse.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   st_valid/ready request handshake (ready only in IDLE)
//   st_size/addr/data  request: size code, byte address, register value
//   mem_addr       word address, registered at accept
//   mem_rd_en      read strobe (data returns next cycle on mem_rd_data)
//   mem_rd_data    synchronous read data
//   mem_wr_en      one-cycle write strobe with mem_wr_data
//   done           one-cycle pulse with the write
//   misaligned     one-cycle pulse for a rejected request
module store_merge_unit
  import store_merge_unit_pkg::*;
#(
  parameter int N      = 32,
  parameter int MEM_AW = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [31:0]       st_addr,
  input  logic [N-1:0]      st_data,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [N-1:0]      mem_rd_data,
  output logic              mem_wr_en,
  output logic [N-1:0]      mem_wr_data,
  output logic              done,
  output logic              misaligned
);

  state_e      state;
  mem_size_e   size_q;
  logic [1:0]  offset_q;
  logic [N-1:0] data_q;

  mem_size_e   req_size;
  mem_size_e   sel_size;
  logic [1:0]  sel_offset;
  logic [N-1:0] sel_data;
  logic [N-1:0] merged;

  assign req_size = mem_size_e'(st_size);

  // One merger serves both paths: in IDLE it sees the incoming request (a
  // word store ignores old_word), afterwards the latched request together
  // with the word returned by the memory read.
  assign sel_size   = (state == S_IDLE) ? req_size     : size_q;
  assign sel_offset = (state == S_IDLE) ? st_addr[1:0] : offset_q;
  assign sel_data   = (state == S_IDLE) ? st_data      : data_q;

  store_lane_merge u_lane_merge (
    .old_word (mem_rd_data),
    .data     (sel_data),
    .size     (sel_size),
    .offset   (sel_offset),
    .merged   (merged)
  );

  // Address bits above the memory's reach are intentionally dropped.
  if (MEM_AW < 30) begin : g_unused_addr
    logic unused_addr_bits;
    assign unused_addr_bits = ^st_addr[31:MEM_AW+2];
  end

  // All outputs are registered: each is set on the edge that enters the
  // state in which it must be visible, and strobes default low every cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      st_ready    <= 1'b1;
      size_q      <= MEM_SIZE_BYTE;
      offset_q    <= 2'b00;
      data_q      <= '0;
      mem_addr    <= '0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      done        <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;

      case (state)
        S_IDLE: begin
          if (st_valid) begin
            size_q   <= req_size;
            offset_q <= st_addr[1:0];
            data_q   <= st_data;
            mem_addr <= st_addr[MEM_AW+1:2];
            st_ready <= 1'b0;
            if (is_misaligned(req_size, st_addr[1:0])) begin
              state      <= S_ERR;
              misaligned <= 1'b1;
            end else if (req_size == MEM_SIZE_WORD) begin
              state       <= S_WRITE;
              mem_wr_en   <= 1'b1;
              done        <= 1'b1;
              mem_wr_data <= merged;
            end else begin
              state     <= S_READ;
              mem_rd_en <= 1'b1;
            end
          end
        end
        S_READ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Read data is valid now; the merged word is captured straight
          // into the write-data register so the write issues next cycle.
          state       <= S_WRITE;
          mem_wr_data <= merged;
          mem_wr_en   <= 1'b1;
          done        <= 1'b1;
        end
        S_WRITE, S_ERR: begin
          state    <= S_IDLE;
          st_ready <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          st_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [29:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic        done;
  logic        misaligned;

  store_merge_unit #(.N(32), .MEM_AW(30)) dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_size     (st_size),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .done        (done),
    .misaligned  (misaligned)
  );

  always #5 clk = ~clk;

  // Simple synchronous data memory driven by the DUT.
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr[5:0]];
    if (mem_wr_en) mem[mem_addr[5:0]] <= mem_wr_data;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference rules expressed with masks and shifts.
  function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] data,
                                            input logic [1:0] size, input logic [31:0] addr);
    int unsigned sh;
    logic [31:0] mask;
    sh = 8 * (addr % 4);
    case (size)
      2'd0:    mask = 32'h0000_00FF << sh;
      2'd1:    mask = 32'h0000_FFFF << sh;
      2'd2:    mask = 32'hFFFF_FFFF;
      default: mask = 32'h0;
    endcase
    return (old & ~mask) | ((data << sh) & mask);
  endfunction

  // Issue one store and check the cycle-by-cycle output timeline.
  task automatic run_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_wd, input bit exp_err, input string tag);
    int n;
    int last;
    logic [4:0] exp_flags;
    @(negedge clk);
    n = 0;
    while (!st_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!st_ready) begin
      check({tag, "_ready_timeout"}, {31'b0, st_ready}, 32'd1);
      return;
    end
    st_valid = 1'b1;
    st_size  = size;
    st_addr  = addr;
    st_data  = data;
    @(posedge clk);
    #1 st_valid = 1'b0;
    last = exp_err ? 1 : ((size == 2'd2) ? 1 : 3);
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      // flags = {st_ready, mem_rd_en, mem_wr_en, done, misaligned}
      if (c == last + 1)      exp_flags = 5'b10000;
      else if (exp_err)       exp_flags = 5'b00001;
      else if (size == 2'd2)  exp_flags = 5'b00110;
      else if (c == 1)        exp_flags = 5'b01000;
      else if (c == 2)        exp_flags = 5'b00000;
      else                    exp_flags = 5'b00110;
      check($sformatf("%s_c%0d_flags", tag, c),
            {27'b0, st_ready, mem_rd_en, mem_wr_en, done, misaligned}, {27'b0, exp_flags});
      if (c <= last)
        check($sformatf("%s_c%0d_mem_addr", tag, c), {2'b00, mem_addr}, addr >> 2);
      if (!exp_err && c == last)
        check($sformatf("%s_wr_data", tag), mem_wr_data, exp_wd);
    end
    if (!exp_err) ref_mem[addr[7:2]] = exp_wd;
  endtask

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pre;
    logic [31:0] exp_wd;
    bit          err;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [31:0] d [3];
    logic [31:0] e [3];
    int acc [3];
    int req;
    int wr_seen;
    bit take;
    int wr_during_rst;

    tbl[0] = '{2'd2, 32'h10, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{2'd0, 32'h13, 32'h123456AB, 32'h11223344, 32'hAB223344, 1'b0};
    tbl[2] = '{2'd1, 32'h22, 32'hFFFF5A5A, 32'hCAFEBABE, 32'h5A5ABABE, 1'b0};
    tbl[3] = '{2'd1, 32'h20, 32'hFFFF5A5A, 32'hCAFEBABE, 32'hCAFE5A5A, 1'b0};
    tbl[4] = '{2'd1, 32'h01, 32'h0000BEEF, 32'h00000000, 32'h00000000, 1'b1};
    tbl[5] = '{2'd2, 32'h06, 32'h01234567, 32'h00000000, 32'h00000000, 1'b1};
    tbl[6] = '{2'd3, 32'h40, 32'h89ABCDEF, 32'h00000000, 32'h00000000, 1'b1};
    tbl[7] = '{2'd0, 32'h30, 32'h000000CD, 32'hFFFFFFFF, 32'hFFFFFFCD, 1'b0};
    tbl[8] = '{2'd0, 32'h35, 32'hFFFFFF00, 32'h87654321, 32'h87650021, 1'b0};

    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end

    st_valid = 1'b0;
    st_size  = 2'd0;
    st_addr  = 32'h0;
    st_data  = 32'h0;
    rst      = 1'b1;
    #2;
    check("reset_flags", {27'b0, st_ready, mem_rd_en, mem_wr_en, done, misaligned}, 32'h10);
    check("reset_mem_addr", {2'b00, mem_addr}, 32'h0);
    check("reset_wr_data", mem_wr_data, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      mem[tbl[i].addr[7:2]]     = tbl[i].pre;
      ref_mem[tbl[i].addr[7:2]] = tbl[i].pre;
      run_store(tbl[i].size, tbl[i].addr, tbl[i].data, tbl[i].exp_wd, tbl[i].err,
                $sformatf("tbl%0d", i));
    end

    // Randomized stores against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  sz;
      logic [31:0] ad;
      logic [31:0] dt;
      sz = 2'($urandom % 4);
      ad = ($urandom % 64) * 4 + ($urandom % 4);
      dt = $urandom;
      run_store(sz, ad, dt, ref_merge(ref_mem[ad[7:2]], dt, sz, ad), ref_err(sz, ad),
                $sformatf("rnd%0d", i));
    end

    // Reset while waiting for read data of an sb: store abandoned.
    mem[24]     = 32'h11111111;
    ref_mem[24] = 32'h11111111;
    @(negedge clk);
    st_valid = 1'b1;
    st_size  = 2'd0;
    st_addr  = 32'h61;
    st_data  = 32'h22;
    @(posedge clk);
    #1 st_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_flags", {27'b0, st_ready, mem_rd_en, mem_wr_en, done, misaligned}, 32'h10);
    check("rstmid_mem_addr", {2'b00, mem_addr}, 32'h0);
    check("rstmid_wr_data", mem_wr_data, 32'h0);
    wr_during_rst = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_wr_en) wr_during_rst++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_wr_en) wr_during_rst++;
    end
    check("rstmid_no_write", wr_during_rst, 0);
    check("rstmid_ready", {31'b0, st_ready}, 32'd1);
    check("rstmid_mem_kept", mem[24], 32'h11111111);

    // st_valid held high across three sb requests to one word.
    mem[32]     = 32'hA5A5A5A5;
    ref_mem[32] = 32'hA5A5A5A5;
    d[0] = 32'h00000011;
    d[1] = 32'hFFFFFF22;
    d[2] = 32'h12345633;
    e[0] = ref_merge(ref_mem[32], d[0], 2'd0, 32'h80);
    e[1] = ref_merge(e[0], d[1], 2'd0, 32'h81);
    e[2] = ref_merge(e[1], d[2], 2'd0, 32'h82);
    acc = '{0, 0, 0};
    req = 0;
    wr_seen = 0;
    @(negedge clk);
    st_valid = 1'b1;
    st_size  = 2'd0;
    st_addr  = 32'h80;
    st_data  = d[0];
    for (int n = 0; n < 30 && wr_seen < 3; n++) begin
      if (mem_wr_en) begin
        check($sformatf("b2b_wr%0d", wr_seen), mem_wr_data, e[wr_seen]);
        wr_seen++;
      end
      take = st_valid && st_ready;
      @(posedge clk);
      if (take) begin
        acc[req] = cyc;
        req++;
        #1;
        if (req < 3) begin
          st_addr = 32'h80 + 32'(req);
          st_data = d[req];
        end else begin
          st_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    st_valid = 1'b0;
    ref_mem[32] = e[2];
    check("b2b_writes", wr_seen, 3);
    check("b2b_gap01", acc[1] - acc[0], 4);
    check("b2b_gap12", acc[2] - acc[1], 4);
    repeat (3) @(negedge clk);

    // Final memory image against the reference.
    for (int i = 0; i < 64; i++)
      check($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
